// File: rtl/sstv_pixel_tx.sv
// sstv_pixel_tx: turns a stream of 2-bit grey pixels into one SSTV scan line
// of 12-bit tone-frequency words (sync, porch, one timed slot per pixel).
module sstv_pixel_tx #(
    parameter int LINE_PIXELS = 160,
    parameter int PIXEL_TICKS = 30,
    parameter int SYNC_TICKS  = 3000,
    parameter int PORCH_TICKS = 200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  pix_color,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [11:0] freq,
    output logic        tone_en,
    output logic        busy,
    output logic        line_done,
    output logic        underrun
);

    localparam int MAXT_SP = (SYNC_TICKS > PORCH_TICKS) ? SYNC_TICKS : PORCH_TICKS;
    localparam int MAXT    = (MAXT_SP > PIXEL_TICKS) ? MAXT_SP : PIXEL_TICKS;
    localparam int TW      = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam int PW      = $clog2(LINE_PIXELS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SYNC  = 2'd1;
    localparam logic [1:0] S_PORCH = 2'd2;
    localparam logic [1:0] S_PIXEL = 2'd3;

    localparam logic [11:0] F_SYNC  = 12'd1200;
    localparam logic [11:0] F_PORCH = 12'd1500;
    localparam logic [11:0] F_BLACK = 12'd1600;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [PW-1:0] slot_q, slot_d;
    logic [PW-1:0] acc_q, acc_d;
    logic          hold_full_q, hold_full_d;
    logic [1:0]    hold_q, hold_d;
    logic [11:0]   freq_q, freq_d;
    logic          tone_q, tone_d;
    logic          done_q, done_d;
    logic          under_q, under_d;
    logic          slot_start;
    logic          hs;

    // Grey level to tone: 1600 Hz plus 200 Hz per step, centred in decode bins.
    function automatic logic [11:0] col_freq(input logic [1:0] c);
        return F_BLACK + ({10'd0, c} * 12'd200);
    endfunction

    assign busy      = (state_q != S_IDLE);
    assign pix_ready = busy & ~hold_full_q & (acc_q < PW'(LINE_PIXELS));
    assign hs        = pix_valid & pix_ready;

    assign freq      = freq_q;
    assign tone_en   = tone_q;
    assign line_done = done_q;
    assign underrun  = under_q;

    // Next-state: line sequencing, hold register and registered tone word.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        slot_d      = slot_q;
        acc_d       = acc_q;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        freq_d      = freq_q;
        tone_d      = tone_q;
        done_d      = 1'b0;
        under_d     = 1'b0;
        slot_start  = 1'b0;

        if (hs) begin
            hold_full_d = 1'b1;
            hold_d      = pix_color;
            acc_d       = acc_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                freq_d = 12'd0;
                tone_d = 1'b0;
                if (start) begin
                    state_d     = S_SYNC;
                    tick_d      = TW'(SYNC_TICKS - 1);
                    acc_d       = '0;
                    hold_full_d = 1'b0;
                    freq_d      = F_SYNC;
                    tone_d      = 1'b1;
                end
            end
            S_SYNC: begin
                if (tick_q == '0) begin
                    state_d = S_PORCH;
                    tick_d  = TW'(PORCH_TICKS - 1);
                    freq_d  = F_PORCH;
                end else begin
                    tick_d = tick_q - 1'b1;
                end
            end
            S_PORCH: begin
                if (tick_q == '0) begin
                    state_d    = S_PIXEL;
                    slot_d     = PW'(1);
                    slot_start = 1'b1;
                end else begin
                    tick_d = tick_q - 1'b1;
                end
            end
            S_PIXEL: begin
                if (tick_q == '0) begin
                    if (slot_q == PW'(LINE_PIXELS)) begin
                        state_d     = S_IDLE;
                        tick_d      = '0;
                        slot_d      = '0;
                        freq_d      = 12'd0;
                        tone_d      = 1'b0;
                        done_d      = 1'b1;
                        hold_full_d = 1'b0;
                    end else begin
                        slot_d     = slot_q + 1'b1;
                        slot_start = 1'b1;
                    end
                end else begin
                    tick_d = tick_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A slot always plays: the held pixel if there is one, else black.
        if (slot_start) begin
            tick_d = TW'(PIXEL_TICKS - 1);
            if (hold_full_q) begin
                freq_d      = col_freq(hold_q);
                hold_full_d = 1'b0;
            end else begin
                freq_d  = F_BLACK;
                under_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            slot_q      <= '0;
            acc_q       <= '0;
            hold_full_q <= 1'b0;
            hold_q      <= 2'd0;
            freq_q      <= 12'd0;
            tone_q      <= 1'b0;
            done_q      <= 1'b0;
            under_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            slot_q      <= slot_d;
            acc_q       <= acc_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            freq_q      <= freq_d;
            tone_q      <= tone_d;
            done_q      <= done_d;
            under_q     <= under_d;
        end
    end

endmodule

// File: tb/tb_sstv_pixel_tx.sv
// tb_sstv_pixel_tx: line-timing model plus directed and random scenarios
// for sstv_pixel_tx with a small line (4 pixels, 3/5/2 ticks).
module tb_sstv_pixel_tx;

    localparam int N  = 4;
    localparam int PT = 3;
    localparam int S  = 5;
    localparam int P  = 2;
    localparam int L  = S + P + N * PT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  pix_color = 2'd0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [11:0] freq;
    logic        tone_en;
    logic        busy;
    logic        line_done;
    logic        underrun;

    sstv_pixel_tx #(
        .LINE_PIXELS(N),
        .PIXEL_TICKS(PT),
        .SYNC_TICKS(S),
        .PORCH_TICKS(P)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .pix_color(pix_color),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .freq(freq),
        .tone_en(tone_en),
        .busy(busy),
        .line_done(line_done),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: position in the line as a cycle index, plus hold state.
    bit m_act, m_hold, m_done, m_under, m_rdy, m_hs;
    int m_t, m_acc, m_col, m_holdc;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_act = 0; m_hold = 0; m_done = 0; m_under = 0;
            m_t = 0; m_acc = 0; m_col = 0; m_holdc = 0;
        end else begin
            m_rdy = m_act && !m_hold && (m_acc < N);
            m_hs  = m_rdy && pix_valid;
            m_done = 0;
            m_under = 0;
            if (!m_act) begin
                if (start) begin
                    m_act = 1; m_t = 1; m_acc = 0; m_hold = 0;
                end
            end else if (m_t == L) begin
                m_act = 0;
                m_done = 1;
            end else begin
                m_t++;
                if (m_t > S + P && ((m_t - S - P - 1) % PT) == 0) begin
                    if (m_hold) begin
                        m_col = m_holdc;
                        m_hold = 0;
                    end else begin
                        m_col = 0;
                        m_under = 1;
                    end
                end
            end
            if (m_hs) begin
                m_hold = 1;
                m_holdc = int'(pix_color);
                m_acc++;
            end
            if (m_done) m_hold = 0;
        end
    end

    function automatic int exp_freq();
        if (!m_act) return 0;
        if (m_t <= S) return 1200;
        if (m_t <= S + P) return 1500;
        return 1600 + 200 * m_col;
    endfunction

    // Every cycle: DUT outputs against the model, sampled on the falling edge.
    always @(negedge clk) begin
        chk("freq", int'(freq), exp_freq());
        chk("tone_en", int'(tone_en), int'(m_act));
        chk("busy", int'(busy), int'(m_act));
        chk("pix_ready", int'(pix_ready), int'(m_act && !m_hold && m_acc < N));
        chk("line_done", int'(line_done), int'(m_done));
        chk("underrun", int'(underrun), int'(m_under));
    end

    int hs_cnt = 0;
    always @(posedge clk) begin
        if (reset_n && pix_valid && pix_ready) hs_cnt++;
    end

    int         lc;
    int         hs_base;
    int         vfrom;
    bit         rnd;
    logic [1:0] src [4];

    function automatic int decode(input int f);
        if (f < 1700) return 0;
        if (f < 1900) return 1;
        if (f < 2100) return 2;
        return 3;
    endfunction

    task automatic drive();
        int hl;
        hl = hs_cnt - hs_base;
        if (rnd) begin
            pix_valid = 1'($urandom_range(0, 1));
            pix_color = 2'($urandom_range(0, 3));
        end else begin
            pix_valid = (lc >= vfrom);
            pix_color = (hl < 4) ? src[hl] : 2'($urandom_range(0, 3));
        end
    endtask

    task automatic step();
        @(negedge clk);
        lc++;
        drive();
    endtask

    task automatic begin_line();
        @(negedge clk);
        lc = 0;
        hs_base = hs_cnt;
        start = 1'b1;
        drive();
        step();
        start = 1'b0;
    endtask

    int nom_f [20] = '{1200, 1200, 1200, 1200, 1200, 1500, 1500,
                       1600, 1600, 1600, 1800, 1800, 1800,
                       2000, 2000, 2000, 2200, 2200, 2200, 0};
    int dcount;
    bit ready_after;

    initial begin
        rnd = 0;
        vfrom = 0;
        lc = 0;
        hs_base = 0;
        src[0] = 2'd0; src[1] = 2'd1; src[2] = 2'd2; src[3] = 2'd3;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_freq", int'(freq), 0);
        chk("idle_busy", int'(busy), 0);

        // Nominal line, pixels always valid.
        begin_line();
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) step();
            chk($sformatf("nom_freq_c%0d", k), int'(freq), nom_f[k-1]);
            if (k == 9 || k == 12 || k == 15 || k == 18)
                chk($sformatf("loopback_s%0d", (k - 8) / 3),
                    decode(int'(freq)), int'(src[(k - 8) / 3]));
        end
        chk("nom_line_done_c20", int'(line_done), 1);
        chk("nom_handshakes", hs_cnt - hs_base, 4);
        repeat (3) step();

        // Late first pixel: slot 0 underruns, pixel lands in slot 1.
        src[0] = 2'd2; src[1] = 2'd3; src[2] = 2'd1; src[3] = 2'd0;
        vfrom = 9;
        begin_line();
        for (int k = 2; k <= 20; k++) begin
            step();
            if (k == 8) begin
                chk("und_pulse_c8", int'(underrun), 1);
                chk("und_freq_c8", int'(freq), 1600);
            end
            if (k == 11) chk("und_slot1_c11", int'(freq), 2000);
        end
        chk("und_line_done_c20", int'(line_done), 1);
        vfrom = 0;
        repeat (3) step();

        // Starts while busy are ignored; start in the done cycle chains a line.
        dcount = 0;
        begin_line();
        for (int k = 2; k <= 40; k++) begin
            step();
            if (line_done) dcount++;
            start = (k == 3 || k == 12 || k == 20);
            if (k == 20) begin
                chk("ign_done_count", dcount, 1);
                hs_base = hs_cnt;
            end
            if (k == 21) begin
                chk("b2b_busy_c21", int'(busy), 1);
                chk("b2b_freq_c21", int'(freq), 1200);
            end
        end
        start = 1'b0;
        chk("b2b_done_count", dcount, 2);
        repeat (3) step();

        // Excess pixels: valid held high, only four accepted.
        ready_after = 0;
        begin_line();
        for (int k = 2; k <= 20; k++) begin
            step();
            if (hs_cnt - hs_base >= 4 && pix_ready) ready_after = 1;
        end
        chk("exc_handshakes", hs_cnt - hs_base, 4);
        chk("exc_ready_after4", int'(ready_after), 0);
        repeat (3) step();

        // Asynchronous reset mid-SYNC.
        begin_line();
        step();
        step();
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_freq", int'(freq), 0);
        chk("rst_tone", int'(tone_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(pix_ready), 0);
        chk("rst_done", int'(line_done), 0);
        chk("rst_under", int'(underrun), 0);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        repeat (4) step();
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_freq", int'(freq), 0);

        // Random traffic checked by the model.
        rnd = 1;
        for (int c = 0; c < 600; c++) begin
            step();
            start = ($urandom_range(0, 9) == 0);
        end
        start = 1'b0;
        repeat (25) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
